// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port for imem_loader.
// master = stream source / memory side, slave = the loader.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready,
        output imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed big-endian program image into instruction memory and holds the CPU
// in reset until done. Define IMEM_LOADER_CKSUM_EN to require the trailing XOR checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    imem_loader_if.slave bus,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERR
    } state_t;

    localparam logic [7:0]  SYNC  = 8'hA5;
    localparam logic [16:0] LIMIT = 17'(1) << ADDR_WIDTH;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam state_t END_STATE = S_CHECK;
`else
    localparam state_t END_STATE = S_DONE;
`endif

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            lane_q, lane_d;
    logic [15:0]           word_count_q, word_count_d;
    logic                  in_ready_q, in_ready_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  xfer;
    logic [15:0]           len_new;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]            cksum_q, cksum_d;
`endif

    assign xfer    = bus.in_valid && in_ready_q;
    assign len_new = {len_q[15:8], bus.in_data};

    // State register plus datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            word_q       <= '0;
            lane_q       <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_q       <= word_d;
            lane_q       <= lane_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q      <= cksum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_d       = word_q;
        lane_d       = lane_q;
        word_count_d = word_count_q;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d      = cksum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (xfer && bus.in_data == SYNC) begin
                    state_d      = S_LEN_HI;
                    word_count_d = '0;
                    lane_d       = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                    cksum_d      = '0;
`endif
                end
            end
            S_LEN_HI: begin
                if (xfer) begin
                    len_d   = {bus.in_data, len_q[7:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (xfer) begin
                    len_d = len_new;
                    if ({1'b0, len_new} > LIMIT)
                        state_d = S_ERR;
                    else if (len_new == 16'd0)
                        state_d = END_STATE;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    word_d = {word_q[23:0], bus.in_data};
                    lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ bus.in_data;
`endif
                    if (lane_q == 2'd3)
                        state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + 16'd1;
                state_d = (word_count_q + 16'd1 == len_q) ? END_STATE : S_DATA;
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CHECK: begin
                if (xfer)
                    state_d = (bus.in_data == cksum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode the upcoming state so they are flopped alongside it
    always_comb begin
        in_ready_d   = (state_d != S_WRITE);
        imem_we_d    = (state_d == S_WRITE);
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        if (imem_we_d) begin
            imem_addr_d  = word_count_q[ADDR_WIDTH-1:0];
            imem_wdata_d = word_d;
        end
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; stream bytes are driven on the falling edge and
// writes are logged just after each rising edge.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_hold, done, error;
    logic [15:0] word_count;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  wa [0:1023];
    logic [31:0] wd [0:1023];
    int          wr_n = 0;
    int          rdy_low = 0;
    int          we_rdy_bad = 0;
    logic [7:0]  q [$];

    imem_loader_if #(.ADDR_WIDTH(8)) bus ();

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (bus.imem_we === 1'b1) begin
            if (wr_n < 1024) begin
                wa[wr_n] = bus.imem_addr;
                wd[wr_n] = bus.imem_wdata;
            end
            wr_n++;
        end
        if (bus.in_ready === 1'b0) rdy_low++;
        if (bus.imem_we !== ~bus.in_ready) we_rdy_bad++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("handshake_timeout", 32'(guard), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_q(input bit bp);
        foreach (q[i]) begin
            if (bp) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(q[i]);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_two_word(input string tag, input int base, input int rbase);
        check({tag, "_nwr"},   32'(wr_n - base), 32'd2);
        check({tag, "_a0"},    32'(wa[base]), 32'd0);
        check({tag, "_d0"},    wd[base], 32'h20080064);
        check({tag, "_a1"},    32'(wa[base + 1]), 32'd1);
        check({tag, "_d1"},    wd[base + 1], 32'h20090019);
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_wc"},    32'(word_count), 32'd2);
        check({tag, "_rdylo"}, 32'(rdy_low - rbase), 32'd2);
    endtask

    initial begin
        int base, rbase, bad;
        logic [7:0] ck;
        logic [31:0] w;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_we",       32'(bus.imem_we), 32'd0);
        check("rst_addr",     32'(bus.imem_addr), 32'd0);
        check("rst_wdata",    bus.imem_wdata, 32'd0);
        check("rst_hold",     32'(cpu_hold), 32'd1);
        check("rst_done",     32'(done), 32'd0);
        check("rst_error",    32'(error), 32'd0);
        check("rst_wc",       32'(word_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single word, with write and done latency checked cycle by cycle
        base = wr_n;
        q = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h64};
        send_q(1'b0);
        check("w1_we_lat",    32'(bus.imem_we), 32'd1);
        check("w1_ready_lo",  32'(bus.in_ready), 32'd0);
        check("w1_addr",      32'(bus.imem_addr), 32'd0);
        check("w1_wdata",     bus.imem_wdata, 32'h20080064);
`ifdef IMEM_LOADER_CKSUM_EN
        send_byte(8'h4C);
`else
        check("w1_done_early", 32'(done), 32'd0);
        @(negedge clk);
`endif
        check("w1_done",  32'(done), 32'd1);
        check("w1_hold",  32'(cpu_hold), 32'd0);
        check("w1_wc",    32'(word_count), 32'd1);
        check("w1_nwr",   32'(wr_n - base), 32'd1);

        // Two words
        base = wr_n; rbase = rdy_low;
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h64, 8'h20, 8'h09, 8'h00, 8'h19};
`ifdef IMEM_LOADER_CKSUM_EN
        q.push_back(8'h7C);
`endif
        send_q(1'b0);
        settle();
        check_two_word("w2", base, rbase);

`ifdef IMEM_LOADER_CKSUM_EN
        // Bad checksum, then recovery
        base = wr_n;
        q = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h64, 8'h4D};
        send_q(1'b0);
        check("bad_nwr",   32'(wr_n - base), 32'd1);
        check("bad_error", 32'(error), 32'd1);
        check("bad_done",  32'(done), 32'd0);
        check("bad_hold",  32'(cpu_hold), 32'd1);
        q = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h64, 8'h4C};
        send_q(1'b0);
        check("rec_done",  32'(done), 32'd1);
        check("rec_error", 32'(error), 32'd0);
`endif

        // Oversize length: 257 words with 8-bit addressing
        base = wr_n;
        q = '{8'hA5, 8'h01, 8'h01};
        send_q(1'b0);
        check("big_error", 32'(error), 32'd1);
        check("big_done",  32'(done), 32'd0);
        check("big_hold",  32'(cpu_hold), 32'd1);
        settle();
        check("big_nwr",   32'(wr_n - base), 32'd0);

        // Empty image
        q = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CKSUM_EN
        q.push_back(8'h00);
`endif
        send_q(1'b0);
        settle();
        check("empty_done",  32'(done), 32'd1);
        check("empty_error", 32'(error), 32'd0);
        check("empty_wc",    32'(word_count), 32'd0);
        check("empty_nwr",   32'(wr_n - base), 32'd0);

        // Junk ahead of sync
        base = wr_n;
        q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef IMEM_LOADER_CKSUM_EN
        q.push_back(8'h08);
`endif
        send_q(1'b0);
        settle();
        check("junk_done",  32'(done), 32'd1);
        check("junk_nwr",   32'(wr_n - base), 32'd1);
        check("junk_wdata", wd[base], 32'h12345678);

        // Exactly 256 words fills the memory
        base = wr_n;
        ck = 8'h00;
        q = '{8'hA5, 8'h01, 8'h00};
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'h3C, 8'(i) ^ 8'hC3};
            for (int k = 3; k >= 0; k--) begin
                q.push_back(w[k*8 +: 8]);
                ck = ck ^ w[k*8 +: 8];
            end
        end
`ifdef IMEM_LOADER_CKSUM_EN
        q.push_back(ck);
`endif
        send_q(1'b0);
        settle();
        check("full_done", 32'(done), 32'd1);
        check("full_wc",   32'(word_count), 32'd256);
        check("full_nwr",  32'(wr_n - base), 32'd256);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'h3C, 8'(i) ^ 8'hC3};
            if (wa[base + i] !== 8'(i) || wd[base + i] !== w) bad++;
        end
        check("full_contents", 32'(bad), 32'd0);

        // Reset in the middle of a frame
        base = wr_n;
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08};
        send_q(1'b0);
        #2 reset = 1'b0;
        #1;
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_we",       32'(bus.imem_we), 32'd0);
        check("mrst_addr",     32'(bus.imem_addr), 32'd0);
        check("mrst_wdata",    bus.imem_wdata, 32'd0);
        check("mrst_hold",     32'(cpu_hold), 32'd1);
        check("mrst_wc",       32'(word_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        q = '{8'h00, 8'h64};
        send_q(1'b0);
        settle();
        check("mrst_nwr",  32'(wr_n - base), 32'd0);
        check("mrst_hold2", 32'(cpu_hold), 32'd1);
        check("mrst_done",  32'(done), 32'd0);

        // Two words again with random gaps on in_valid
        base = wr_n; rbase = rdy_low;
        q = '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h64, 8'h20, 8'h09, 8'h00, 8'h19};
`ifdef IMEM_LOADER_CKSUM_EN
        q.push_back(8'h7C);
`endif
        send_q(1'b1);
        settle();
        check_two_word("bp", base, rbase);

        check("we_vs_ready", 32'(we_rdy_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
